upsampling_layer: RTL and testbench
===================================

Name: upsampling_layer

Overview:
- Streaming nearest-neighbour upsampler; the inverse of pooling_layer.
- Consumes a raster-order pixel stream of an IMAGE_SIZE-wide image.
- Emits each pixel SCALE times horizontally and each row SCALE times vertically.
- Sits after pooling/conv stages in decoder-style pipelines.
- A single-row line buffer replays rows, so the input must be stalled via input_ready during replay.

Parameters:
- I_WIDTH, 8: bits per channel sample.
- CHANNELS, 3: channels packed per pixel; channel 0 is in the LSBs.
- IMAGE_SIZE, 32: input image width in pixels. Output width is IMAGE_SIZE*SCALE.
- SCALE, 2: upsampling factor in both dimensions; must be at least 2.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- clk_en, input, 1: global enable. When low, all state is frozen.
- input_data, input, CHANNELS*I_WIDTH: input pixel.
- input_valid, input, 1: input_data is valid this cycle.
- input_ready, output, 1: the block accepts input this cycle.
- output_data, output, CHANNELS*I_WIDTH: output pixel, registered.
- valid, output, 1: output_data is valid. Single-cycle strobe; there is no output backpressure.

Behaviour:
- Accept condition: a pixel is accepted on a rising edge where input_valid && input_ready.
- input_ready (combinational) = !reset && clk_en && state==FILL && rep_cnt==0.
- Reset:
  - valid=0, output_data=0, state=FILL.
  - col=0, rep_cnt=0, row_rep=0, held pixel=0.
  - Line buffer contents are don't-care.
  - Reset mid-row discards the partial row; the next accepted pixel is treated as column 0 of a new row.
- clk_en low: no state changes, and valid<=0 on that edge. Resuming continues exactly where the block stopped.
- Counters:
  - col: 0..IMAGE_SIZE-1.
  - rep_cnt: 0..SCALE-1, horizontal repeats remaining.
  - row_rep: 1..SCALE-1, index of the replayed row.
- State FILL (first output row of each input row):
  - On accept:
    - line_buf[col]<=input_data, held<=input_data.
    - output_data<=input_data, valid<=1, rep_cnt<=SCALE-1.
  - Else if rep_cnt!=0:
    - output_data<=held, valid<=1, rep_cnt<=rep_cnt-1.
    - When rep_cnt==1: if col==IMAGE_SIZE-1 then col<=0, row_rep<=1, state<=REPLAY; else col<=col+1.
  - Else (idle, no input): valid<=0; this is a bubble.
- State REPLAY (rows 1..SCALE-1):
  - Every enabled cycle: output_data<=line_buf[col], valid<=1.
  - rep_cnt counts SCALE-1 down to 0 per column.
  - A column's repeats are done when the cycle count for that column reaches SCALE; then col advances.
  - At the end of the last column: col wraps to 0. If row_rep==SCALE-1, state<=FILL; else row_rep<=row_rep+1.
  - In REPLAY rep_cnt is reused as the countdown: it starts at 0, is loaded with SCALE-1 on the column's first cycle, and the column completes when rep_cnt==1 with a decrement to 0.
  - No bubbles occur in REPLAY.
- Latency: an accepted pixel appears on output_data with valid=1 in the cycle after the accept edge.
- Throughput:
  - At most one input per SCALE cycles during FILL.
  - No input during REPLAY, for IMAGE_SIZE*SCALE*(SCALE-1) cycles.
- Output count: every IMAGE_SIZE accepted pixels yield exactly IMAGE_SIZE*SCALE*SCALE valid strobes, in raster order of the upsampled image.
- Ordering: output is strictly in upsampled raster order. Input bubbles only delay output; they never reorder it.
- Line buffer: IMAGE_SIZE x CHANNELS*I_WIDTH registers or inferred RAM with synchronous read. Writes occur only in FILL.
- Counter widths: clog2 of each counter's range, minimum 1 bit.

Test Plan:
- Basic, IMAGE_SIZE=4, SCALE=2, input 01..04 continuous (24-bit pixels 0x010101..0x040404):
  - Required output: 01,01,02,02,03,03,04,04, then 01,01,02,02,03,03,04,04; 16 strobes.
  - input_ready low for the 8 replay cycles.
  - First valid one cycle after the first accept.
- Full frame, defaults (32x16 input, random hex file):
  - Required: exactly 2048 strobes matching the golden upsampled file.
  - Required: total input accepted is 512.
- Input bubbles: input_valid toggled pseudo-randomly at 50%.
  - Required: identical output sequence to the continuous case.
  - Required: valid low only in FILL idle cycles.
- SCALE=3, IMAGE_SIZE=2, input A,B:
  - Required output: A,A,A,B,B,B repeated over 3 rows; 18 strobes.
  - input_ready low for 12 cycles after the first row.
- clk_en low for 5 cycles mid-REPLAY:
  - Required: valid=0 and output_data held during the freeze.
  - Required: the sequence resumes with no skipped or duplicated pixel.
- Reset asserted for 1 cycle mid-FILL after 2 of 4 pixels:
  - Required: valid=0 next cycle.
  - Required: the next 4 inputs produce a clean 16-strobe frame starting at column 0.

Source files
------------

// File: rtl/upsampling_layer.sv
// upsampling_layer: streaming nearest-neighbour upsampler.
// Each accepted pixel is emitted SCALE times horizontally while it is also
// captured into a single-row line buffer. Once a full input row has been
// seen, the row is replayed from the line buffer SCALE-1 more times, and
// the input is stalled (input_ready low) for the whole replay.
module upsampling_layer #(
    parameter int I_WIDTH    = 8,
    parameter int CHANNELS   = 3,
    parameter int IMAGE_SIZE = 32,
    parameter int SCALE      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic [CHANNELS*I_WIDTH-1:0]   input_data,
    input  logic                          input_valid,
    output logic                          input_ready,
    output logic [CHANNELS*I_WIDTH-1:0]   output_data,
    output logic                          valid
);

    localparam int PIX_W = CHANNELS * I_WIDTH;
    localparam int COL_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_SIZE - 1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(SCALE - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t             state_reg;
    logic [COL_W-1:0]   col_reg;
    logic [REP_W-1:0]   rep_cnt_reg;
    logic [REP_W-1:0]   row_rep_reg;
    logic [PIX_W-1:0]   held_reg;
    logic [PIX_W-1:0]   output_data_reg;
    logic               valid_reg;

    // One row of input pixels, written during FILL and replayed afterwards.
    logic [PIX_W-1:0]   line_buf [IMAGE_SIZE];

    logic               accept;

    // New pixels are only taken when the previous one has finished its
    // horizontal repeats and no row is being replayed.
    assign input_ready = !reset && clk_en && (state_reg == FILL) && (rep_cnt_reg == '0);
    assign accept      = input_valid && input_ready;

    assign output_data = output_data_reg;
    assign valid       = valid_reg;

    // Line buffer write port; accept already implies FILL, enabled, not in reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[col_reg] <= input_data;
        end
    end

    // Control FSM: horizontal repeat countdown, column walk and row replay.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= FILL;
            col_reg         <= '0;
            rep_cnt_reg     <= '0;
            row_rep_reg     <= '0;
            held_reg        <= '0;
            output_data_reg <= '0;
            valid_reg       <= 1'b0;
        end else if (!clk_en) begin
            // Frozen: hold everything, but never repeat a strobe.
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        held_reg        <= input_data;
                        output_data_reg <= input_data;
                        valid_reg       <= 1'b1;
                        rep_cnt_reg     <= REP_MAX;
                    end else if (rep_cnt_reg != '0) begin
                        output_data_reg <= held_reg;
                        valid_reg       <= 1'b1;
                        rep_cnt_reg     <= rep_cnt_reg - REP_ONE;
                        if (rep_cnt_reg == REP_ONE) begin
                            if (col_reg == LAST_COL) begin
                                col_reg     <= '0;
                                row_rep_reg <= REP_ONE;
                                state_reg   <= REPLAY;
                            end else begin
                                col_reg <= col_reg + COL_W'(1);
                            end
                        end
                    end else begin
                        // Waiting for input: output bubble.
                        valid_reg <= 1'b0;
                    end
                end

                REPLAY: begin
                    // Synchronous read of the stored row straight into the output register.
                    output_data_reg <= line_buf[col_reg];
                    valid_reg       <= 1'b1;
                    if (rep_cnt_reg == '0) begin
                        // First cycle of a column: arm the countdown.
                        rep_cnt_reg <= REP_MAX;
                    end else begin
                        rep_cnt_reg <= rep_cnt_reg - REP_ONE;
                        if (rep_cnt_reg == REP_ONE) begin
                            if (col_reg == LAST_COL) begin
                                col_reg <= '0;
                                if (row_rep_reg == REP_MAX) begin
                                    state_reg <= FILL;
                                end else begin
                                    row_rep_reg <= row_rep_reg + REP_ONE;
                                end
                            end else begin
                                col_reg <= col_reg + COL_W'(1);
                            end
                        end
                    end
                end

                default: begin
                    state_reg <= FILL;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upsampling_layer.sv
// tb_upsampling_layer: scoreboard bench for upsampling_layer.
// Three instances: d0 = 4 wide x2, d1 = 2 wide x3, d2 = default 32 wide x2.
// Expected pixels are queued as inputs are accepted; a monitor collects
// output strobes and each test task compares them in order.
module tb_upsampling_layer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clk_en;
    logic [23:0] in_data  [3];
    logic        in_valid [3];
    logic        rdy      [3];
    logic        vld      [3];
    logic [23:0] out_d    [3];

    upsampling_layer #(.I_WIDTH(8), .CHANNELS(3), .IMAGE_SIZE(4), .SCALE(2)) u_d0 (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .input_data(in_data[0]), .input_valid(in_valid[0]), .input_ready(rdy[0]),
        .output_data(out_d[0]), .valid(vld[0])
    );

    upsampling_layer #(.I_WIDTH(8), .CHANNELS(3), .IMAGE_SIZE(2), .SCALE(3)) u_d1 (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .input_data(in_data[1]), .input_valid(in_valid[1]), .input_ready(rdy[1]),
        .output_data(out_d[1]), .valid(vld[1])
    );

    upsampling_layer u_d2 (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .input_data(in_data[2]), .input_valid(in_valid[2]), .input_ready(rdy[2]),
        .output_data(out_d[2]), .valid(vld[2])
    );

    int checks = 0;
    int passes = 0;

    logic [23:0] exp_q [$];
    logic [23:0] obs_q [$];

    // Reference model: row store for building the replayed rows.
    logic [23:0] m_row [32];
    int          m_col = 0;

    // Monitor state (written only by the monitor blocks).
    int   strobe_cnt [3] = '{0, 0, 0};
    int   acc_cnt    [3] = '{0, 0, 0};
    int   bad_bubble [3] = '{0, 0, 0};
    logic rdy_q [3];
    logic en_q;
    logic rst_q;

    // Capture pre-edge conditions and count accepted inputs.
    always @(posedge clk) begin
        en_q  <= clk_en;
        rst_q <= reset;
        for (int d = 0; d < 3; d++) begin
            rdy_q[d] <= rdy[d];
            if (in_valid[d] && rdy[d]) acc_cnt[d] <= acc_cnt[d] + 1;
        end
    end

    // Collect output strobes; flag a missing strobe on an edge that was not an idle FILL cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (vld[d] === 1'b1) begin
                obs_q.push_back(out_d[d]);
                strobe_cnt[d] <= strobe_cnt[d] + 1;
            end else if (en_q === 1'b1 && rst_q === 1'b0 && rdy_q[d] !== 1'b1) begin
                bad_bubble[d] <= bad_bubble[d] + 1;
            end
        end
    end

    task automatic model_push(input int d, input logic [23:0] pix);
        int w;
        int s;
        w = (d == 0) ? 4 : (d == 1) ? 2 : 32;
        s = (d == 1) ? 3 : 2;
        m_row[m_col] = pix;
        for (int k = 0; k < s; k++) exp_q.push_back(pix);
        m_col++;
        if (m_col == w) begin
            for (int r = 1; r < s; r++)
                for (int c = 0; c < w; c++)
                    for (int k = 0; k < s; k++) exp_q.push_back(m_row[c]);
            m_col = 0;
        end
    endtask

    task automatic send(input int d, input logic [23:0] pix, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_data[d]  = pix;
        in_valid[d] = 1'b1;
        while (rdy[d] !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (rdy[d] !== 1'b1) begin
            checks++;
            $display("FAIL send_timeout d%0d: input_ready=%b required 1", d, rdy[d]);
        end else begin
            @(posedge clk);
            #1;
            model_push(d, pix);
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (vld[0] !== 1'b0) $display("FAIL reset_valid: got %b required 0", vld[0]); else passes++;
        checks++;
        if (out_d[0] !== 24'h0) $display("FAIL reset_data: got %h required 000000", out_d[0]); else passes++;
        checks++;
        if (rdy[0] !== 1'b0) $display("FAIL reset_ready: got %b required 0", rdy[0]); else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if (rdy[0] !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", rdy[0]); else passes++;
        $display("reset checks done");
    endtask

    task automatic test_basic();
        int s0, a0, n, t;
        logic [23:0] e, o;
        s0 = strobe_cnt[0];
        a0 = acc_cnt[0];
        send(0, 24'h010101, 0);
        @(negedge clk);
        checks++;
        if (vld[0] !== 1'b1) $display("FAIL basic_latency_valid: got %b required 1", vld[0]); else passes++;
        checks++;
        if (out_d[0] !== 24'h010101) $display("FAIL basic_latency_data: got %h required 010101", out_d[0]); else passes++;
        send(0, 24'h020202, 0);
        send(0, 24'h030303, 0);
        send(0, 24'h040404, 0);
        // One horizontal repeat of the last pixel plus 8 replay cycles.
        n = 0;
        @(negedge clk);
        while (rdy[0] !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 9) $display("FAIL basic_ready_low: got %0d cycles required 9", n); else passes++;
        while (exp_q.size() > 0) begin
            t = 0;
            while (obs_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL basic_seq: no strobe, required %h", e);
                exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL basic_seq: got %h required %h", o, e);
                else begin passes++; $display("basic strobe data=%h", o); end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (strobe_cnt[0] - s0 != 16) $display("FAIL basic_strobes: got %0d required 16", strobe_cnt[0] - s0); else passes++;
        checks++;
        if (acc_cnt[0] - a0 != 4) $display("FAIL basic_accepts: got %0d required 4", acc_cnt[0] - a0); else passes++;
        obs_q.delete();
    endtask

    task automatic test_scale3();
        int s0, n, t;
        logic [23:0] e, o;
        s0 = strobe_cnt[1];
        send(1, 24'h0a0b0c, 0);
        send(1, 24'h102030, 0);
        // Two horizontal repeats of B, then 12 replay cycles.
        n = 0;
        @(negedge clk);
        while (rdy[1] !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 14) $display("FAIL scale3_ready_low: got %0d cycles required 14", n); else passes++;
        while (exp_q.size() > 0) begin
            t = 0;
            while (obs_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL scale3_seq: no strobe, required %h", e);
                exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL scale3_seq: got %h required %h", o, e);
                else begin passes++; $display("scale3 strobe data=%h", o); end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (strobe_cnt[1] - s0 != 18) $display("FAIL scale3_strobes: got %0d required 18", strobe_cnt[1] - s0); else passes++;
        obs_q.delete();
    endtask

    task automatic test_bubbles();
        int s0, b0, t;
        logic [23:0] e, o;
        s0 = strobe_cnt[0];
        b0 = bad_bubble[0];
        for (int i = 0; i < 8; i++) send(0, 24'($urandom), int'($urandom_range(0, 1)));
        while (exp_q.size() > 0) begin
            t = 0;
            while (obs_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL bubbles_seq: no strobe, required %h", e);
                exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL bubbles_seq: got %h required %h", o, e);
                else begin passes++; $display("bubbles strobe data=%h", o); end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (strobe_cnt[0] - s0 != 32) $display("FAIL bubbles_strobes: got %0d required 32", strobe_cnt[0] - s0); else passes++;
        checks++;
        if (bad_bubble[0] != b0) $display("FAIL bubbles_gap: got %0d non-idle gaps required 0", bad_bubble[0] - b0); else passes++;
        obs_q.delete();
    endtask

    task automatic test_freeze();
        int s0, t;
        logic [23:0] e, o, held;
        s0 = strobe_cnt[0];
        send(0, 24'h111111, 0);
        send(0, 24'h222222, 0);
        send(0, 24'h333333, 0);
        send(0, 24'h444444, 0);
        repeat (3) @(negedge clk);
        held   = out_d[0];
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (vld[0] !== 1'b0) $display("FAIL freeze_valid: got %b required 0", vld[0]); else passes++;
            checks++;
            if (out_d[0] !== held) $display("FAIL freeze_data: got %h required %h", out_d[0], held); else passes++;
        end
        clk_en = 1'b1;
        while (exp_q.size() > 0) begin
            t = 0;
            while (obs_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL freeze_seq: no strobe, required %h", e);
                exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL freeze_seq: got %h required %h", o, e);
                else begin passes++; $display("freeze strobe data=%h", o); end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (strobe_cnt[0] - s0 != 16) $display("FAIL freeze_strobes: got %0d required 16", strobe_cnt[0] - s0); else passes++;
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int s0, t;
        logic [23:0] e, o;
        send(0, 24'h0f0f0f, 0);
        send(0, 24'h1e1e1e, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (vld[0] !== 1'b0) $display("FAIL midreset_valid: got %b required 0", vld[0]); else passes++;
        checks++;
        if (out_d[0] !== 24'h0) $display("FAIL midreset_data: got %h required 000000", out_d[0]); else passes++;
        reset = 1'b0;
        // Only the first copy of the second pixel escapes before the reset edge.
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL midreset_partial: no strobe, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL midreset_partial: got %h required %h", o, e);
                else begin passes++; $display("midreset strobe data=%h", o); end
            end
        end
        checks++;
        if (obs_q.size() != 0) $display("FAIL midreset_extra: got %0d strobes required 0", obs_q.size()); else passes++;
        exp_q.delete();
        obs_q.delete();
        m_col = 0;
        s0 = strobe_cnt[0];
        send(0, 24'haa0001, 0);
        send(0, 24'haa0002, 0);
        send(0, 24'haa0003, 0);
        send(0, 24'haa0004, 0);
        while (exp_q.size() > 0) begin
            t = 0;
            while (obs_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL midreset_seq: no strobe, required %h", e);
                exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL midreset_seq: got %h required %h", o, e);
                else begin passes++; $display("midreset strobe data=%h", o); end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (strobe_cnt[0] - s0 != 16) $display("FAIL midreset_strobes: got %0d required 16", strobe_cnt[0] - s0); else passes++;
        obs_q.delete();
    endtask

    task automatic test_full_frame();
        int s0, a0, b0, t;
        logic [23:0] e, o;
        s0 = strobe_cnt[2];
        a0 = acc_cnt[2];
        b0 = bad_bubble[2];
        for (int i = 0; i < 512; i++) send(2, 24'($urandom), 0);
        while (exp_q.size() > 0) begin
            t = 0;
            while (obs_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL frame_seq: no strobe, required %h", e);
                exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL frame_seq: got %h required %h", o, e);
                else begin passes++; $display("frame strobe data=%h", o); end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (strobe_cnt[2] - s0 != 2048) $display("FAIL frame_strobes: got %0d required 2048", strobe_cnt[2] - s0); else passes++;
        checks++;
        if (acc_cnt[2] - a0 != 512) $display("FAIL frame_accepts: got %0d required 512", acc_cnt[2] - a0); else passes++;
        checks++;
        if (bad_bubble[2] != b0) $display("FAIL frame_gap: got %0d non-idle gaps required 0", bad_bubble[2] - b0); else passes++;
        obs_q.delete();
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_data[d]  = '0;
            in_valid[d] = 1'b0;
        end
        test_reset();
        test_basic();
        test_scale3();
        test_bubbles();
        test_freeze();
        test_reset_mid();
        test_full_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
